// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared types and constants for the UART transmit arbiter slice.
//   state_e   : arbiter FSM state encoding (IDLE / WAIT_HI / WAIT_LO)
//   DEF_DW    : default byte width
//   DEF_BUSY_TO : default cycles to wait for the UART busy flag to rise
//   STAT_W    : width of each per-requester grant counter
//   TO_W      : width of the busy-rise timeout counter (covers 2..255)
//   grant_w() : grant-index width, max(1, clog2(n))
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_e;

    localparam int DEF_DW      = 8;
    localparam int DEF_BUSY_TO = 16;
    localparam int STAT_W      = 16;
    localparam int TO_W        = 8;

    // A two-requester arbiter still needs one bit of grant index.
    function automatic int grant_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if
// Bundles the producer-side handshake and the UART-side strobe/busy pair
// of the transmit arbiter.
//   i_req_data  : NREQ*DW, requester r byte in [r*DW +: DW]
//   i_req_valid : NREQ, per-requester valid
//   o_req_ready : NREQ, per-requester ready (holding buffer empty)
//   i_tx_busy   : UART transmitter busy
//   o_tx_data   : byte to UART, held until the next strobe
//   o_tx_stb    : one-cycle transmit strobe
//   o_grant_id  : requester index of the last strobe
//   o_timeout   : sticky busy-rise timeout flag
//   o_grant_cnt : NREQ*STAT_W per-requester sent-byte counters
// Modports: slave = arbiter side, master = producers/UART/bench side.
interface uart_tx_arb_if #(
    parameter int NREQ = 2,
    parameter int DW   = 8
);
    import uart_tx_arb_pkg::*;

    localparam int GW = grant_w(NREQ);

    logic [NREQ*DW-1:0]     i_req_data;
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ-1:0]        o_req_ready;
    logic                   i_tx_busy;
    logic [DW-1:0]          o_tx_data;
    logic                   o_tx_stb;
    logic [GW-1:0]          o_grant_id;
    logic                   o_timeout;
    logic [NREQ*STAT_W-1:0] o_grant_cnt;

    modport slave (
        input  i_req_data, i_req_valid, i_tx_busy,
        output o_req_ready, o_tx_data, o_tx_stb, o_grant_id, o_timeout, o_grant_cnt
    );

    modport master (
        output i_req_data, i_req_valid, i_tx_busy,
        input  o_req_ready, o_tx_data, o_tx_stb, o_grant_id, o_timeout, o_grant_cnt
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first set bit of full_i
// scanning ptr_i, ptr_i+1, ... modulo NREQ.
//   full_i     : NREQ request/full vector
//   ptr_i      : GW-bit starting position (highest priority)
//   any_full_o : at least one bit of full_i is set
//   grant_o    : index of the picked bit (0 when nothing is set)
module rr_pick #(
    parameter int NREQ = 2,
    parameter int GW   = 1
) (
    input  logic [NREQ-1:0] full_i,
    input  logic [GW-1:0]   ptr_i,
    output logic            any_full_o,
    output logic [GW-1:0]   grant_o
);

    // Scan from the farthest offset back towards ptr so that the last hit
    // written is the closest one to ptr, i.e. the round-robin winner.
    always_comb begin
        int idx;
        idx        = 0;
        any_full_o = 1'b0;
        grant_o    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (full_i[idx]) begin
                any_full_o = 1'b1;
                grant_o    = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one UART transmitter between NREQ byte producers. Each producer
// owns a one-entry holding buffer; a round-robin pick selects a full buffer,
// issues one strobe to the UART, then follows the UART busy flag up and
// down before the next byte may go out.
// Ports:
//   clk    : system clock
//   arst_i : asynchronous active-high reset
//   bus    : uart_tx_arb_if.slave (producer handshake + UART strobe/busy)
// Parameters: NREQ (2..4), DW, BUSY_TO (2..255).
// Build option: define UART_TX_ARB_STATS_EN to build saturating per-requester
// grant counters on o_grant_cnt; otherwise o_grant_cnt is tied to zero.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = DEF_DW,
    parameter int BUSY_TO = DEF_BUSY_TO
) (
    input  logic           clk,
    input  logic           arst_i,
    uart_tx_arb_if.slave   bus
);

    localparam int            GW       = grant_w(NREQ);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BUSY_TO - 1);
    localparam logic [GW-1:0]   LAST_REQ = GW'(NREQ - 1);

    logic [NREQ-1:0][DW-1:0] buf_q;
    logic [NREQ-1:0]         full_q;
    logic [GW-1:0]           ptr_q;
    state_e                  state_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic [DW-1:0]           tx_data_q;
    logic                    tx_stb_q;
    logic [GW-1:0]           grant_id_q;
    logic                    timeout_q;

    logic                    any_full;
    logic [GW-1:0]           pick;
    logic                    fire_d;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .full_i     (full_q),
        .ptr_i      (ptr_q),
        .any_full_o (any_full),
        .grant_o    (pick)
    );

    // A grant happens only from IDLE with the UART idle, so a strobe can
    // never land on a busy transmitter or follow another strobe directly.
    assign fire_d = (state_q == IDLE) && any_full && !bus.i_tx_busy;

    // Buffer fill, grant and busy tracking share one register block. A
    // buffer being granted is full, so its ready is low and no fill can
    // collide with the clear of the same entry.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            buf_q      <= '0;
            full_q     <= '0;
            ptr_q      <= '0;
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            tx_data_q  <= '0;
            tx_stb_q   <= 1'b0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            tx_stb_q <= 1'b0;

            for (int r = 0; r < NREQ; r++) begin
                if (bus.i_req_valid[r] && !full_q[r]) begin
                    buf_q[r]  <= bus.i_req_data[r*DW +: DW];
                    full_q[r] <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (fire_d) begin
                        tx_data_q    <= buf_q[pick];
                        tx_stb_q     <= 1'b1;
                        grant_id_q   <= pick;
                        full_q[pick] <= 1'b0;
                        ptr_q        <= (pick == LAST_REQ) ? '0 : pick + 1'b1;
                        to_cnt_q     <= '0;
                        state_q      <= WAIT_HI;
                    end
                end
                // Give up on a UART that never acknowledges the strobe so
                // the remaining producers are not starved.
                WAIT_HI: begin
                    if (bus.i_tx_busy) begin
                        state_q <= WAIT_LO;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!bus.i_tx_busy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = ~full_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_stb    = tx_stb_q;
    assign bus.o_grant_id  = grant_id_q;
    assign bus.o_timeout   = timeout_q;

`ifdef UART_TX_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] cnt_q;

    // Counters step on the grant edge and stick at all ones.
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (fire_d && (cnt_q[pick] != '1)) begin
            cnt_q[pick] <= cnt_q[pick] + 1'b1;
        end
    end

    assign bus.o_grant_cnt = cnt_q;
`else
    assign bus.o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Self-checking bench for uart_tx_arb (NREQ=2, DW=8, BUSY_TO=16).
// Builds with or without UART_TX_ARB_STATS_EN; the expected grant counts
// follow the macro.
module tb_uart_tx_arb;
    import uart_tx_arb_pkg::*;

    localparam int NREQ    = 2;
    localparam int DW      = 8;
    localparam int BUSY_TO = 16;

`ifdef UART_TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst_i = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

    uart_tx_arb #(
        .NREQ    (NREQ),
        .DW      (DW),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk    (clk),
        .arst_i (arst_i),
        .bus    (bus)
    );

    logic [NREQ*DW-1:0] tbReqData  = '0;
    logic [NREQ-1:0]    tbReqValid = '0;
    logic               uartAuto   = 1'b1;
    logic               manualBusy = 1'b0;
    logic               autoBusy   = 1'b0;
    int                 busyLen    = 0;
    int                 busyLeft   = 0;

    assign bus.i_req_data  = tbReqData;
    assign bus.i_req_valid = tbReqValid;
    assign bus.i_tx_busy   = uartAuto ? autoBusy : manualBusy;

    int vecCount  = 0;
    int missCount = 0;
    int cycle     = 0;

    typedef struct {
        int id;
        int data;
        int cyc;
    } stb_t;

    stb_t            stbLog[$];
    stb_t            monS;
    logic [DW-1:0]   expQ[NREQ][$];
    int              modelCnt[NREQ];
    logic            scoreOn = 1'b0;
    logic            prevStb = 1'b0;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor and UART model in one process so the busy value the
    // monitor reads is the one the DUT sampled at the preceding edge.
    always @(negedge clk) begin
        if (arst_i) begin
            busyLeft = 0;
            autoBusy = 1'b0;
            prevStb  = 1'b0;
        end else begin
            if (bus.o_tx_stb) begin
                checkOutput("stb_not_back_to_back", {63'd0, prevStb}, 64'd0);
                checkOutput("stb_while_busy", {63'd0, bus.i_tx_busy}, 64'd0);
                monS.id   = int'(bus.o_grant_id);
                monS.data = int'(bus.o_tx_data);
                monS.cyc  = cycle;
                stbLog.push_back(monS);
                if (scoreOn) begin
                    if (expQ[monS.id].size() == 0) begin
                        checkOutput("sb_unexpected_byte", 64'(monS.id), 64'hFF);
                    end else begin
                        checkOutput("sb_byte_order", 64'(monS.data), 64'(expQ[monS.id].pop_front()));
                    end
                    modelCnt[monS.id]++;
                end
            end
            prevStb = bus.o_tx_stb;
            if (uartAuto) begin
                if (bus.o_tx_stb && busyLen > 0) busyLeft = busyLen;
                if (busyLeft > 0) begin
                    autoBusy = 1'b1;
                    busyLeft--;
                end else begin
                    autoBusy = 1'b0;
                end
            end else begin
                autoBusy = 1'b0;
                busyLeft = 0;
            end
        end
    end

    task automatic resetDut();
        arst_i     = 1'b1;
        tbReqValid = '0;
        tbReqData  = '0;
        uartAuto   = 1'b1;
        manualBusy = 1'b0;
        busyLen    = 0;
        scoreOn    = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            expQ[r].delete();
            modelCnt[r] = 0;
        end
        repeat (2) @(posedge clk);
        #1 arst_i = 1'b0;
    endtask

    task automatic applyStimulus(input int r, input logic [DW-1:0] data);
        tbReqValid[r]           = 1'b1;
        tbReqData[r*DW +: DW]   = data;
    endtask

    task automatic waitStrobe(input int base, input int maxCyc, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < maxCyc; k++) begin
            if (stbLog.size() > base) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        checkOutput("strobe_within_budget", {63'd0, ok}, 64'd1);
    endtask

    task automatic waitUartIdle();
        for (int k = 0; k < 100 && bus.i_tx_busy; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string name, input int exp0, input int exp1);
        checkOutput({name, "_cnt0"}, 64'(bus.o_grant_cnt[0 +: STAT_W]), STATS ? 64'(exp0) : 64'd0);
        checkOutput({name, "_cnt1"}, 64'(bus.o_grant_cnt[STAT_W +: STAT_W]), STATS ? 64'(exp1) : 64'd0);
    endtask

    typedef struct {
        int            r;
        logic [DW-1:0] data;
        int            busyCycles;
        int            expId;
        logic [DW-1:0] expData;
        int            expLat;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ok;
        int   base;
        int   startCyc;
        int   tCyc;
        int   sCyc;
        logic [NREQ-1:0] fire;
        int   sent[NREQ];

        tbl[0] = '{0, 8'hA5, 20, 0, 8'hA5, 2};
        tbl[1] = '{1, 8'h5A,  3, 1, 8'h5A, 2};
        tbl[2] = '{0, 8'h00,  1, 0, 8'h00, 2};
        tbl[3] = '{1, 8'hFF,  5, 1, 8'hFF, 2};
        tbl[4] = '{0, 8'h3C,  2, 0, 8'h3C, 2};

        // Reset state, observed while reset is held.
        #1;
        checkOutput("rst_stb", {63'd0, bus.o_tx_stb}, 64'd0);
        checkOutput("rst_data", 64'(bus.o_tx_data), 64'd0);
        checkOutput("rst_grant_id", 64'(bus.o_grant_id), 64'd0);
        checkOutput("rst_timeout", {63'd0, bus.o_timeout}, 64'd0);
        checkOutput("rst_ready", 64'(bus.o_req_ready), 64'(2'b11));
        resetDut();
        checkCounters("rst", 0, 0);

        // Table: single bytes, one requester at a time.
        for (int i = 0; i < 5; i++) begin
            busyLen  = tbl[i].busyCycles;
            base     = stbLog.size();
            @(posedge clk);
            #1;
            applyStimulus(tbl[i].r, tbl[i].data);
            startCyc = cycle;
            @(posedge clk);
            #1;
            tbReqValid = '0;
            waitStrobe(base, 10, ok);
            if (ok) begin
                checkOutput("tbl_data", 64'(stbLog[base].data), 64'(tbl[i].expData));
                checkOutput("tbl_grant_id", 64'(stbLog[base].id), 64'(tbl[i].expId));
                checkOutput("tbl_latency", 64'(stbLog[base].cyc - startCyc), 64'(tbl[i].expLat));
                @(posedge clk);
                #1;
                checkOutput("tbl_ready_during_tx", {63'd0, bus.o_req_ready[tbl[i].r]}, 64'd1);
            end
            waitUartIdle();
        end

        // Contention: both requesters refill on ready, four bytes each.
        resetDut();
        busyLen = 4;
        base    = stbLog.size();
        sent    = '{0, 0};
        @(posedge clk);
        #1;
        applyStimulus(0, 8'h11);
        applyStimulus(1, 8'h22);
        for (int k = 0; k < 300 && tbReqValid != '0; k++) begin
            @(negedge clk);
            fire = tbReqValid & bus.o_req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (fire[r]) begin
                    sent[r]++;
                    if (sent[r] == 4) tbReqValid[r] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 200 && stbLog.size() < base + 8; k++) @(posedge clk);
        waitUartIdle();
        checkOutput("cont_strobe_count", 64'(stbLog.size() - base), 64'd8);
        for (int k = 0; k < 8 && base + k < stbLog.size(); k++) begin
            checkOutput("cont_order_data", 64'(stbLog[base+k].data), (k % 2 == 0) ? 64'h11 : 64'h22);
            checkOutput("cont_order_id", 64'(stbLog[base+k].id), 64'(k % 2));
        end
        checkCounters("cont", 4, 4);

        // UART never raises busy: timeout, then the queued byte goes out.
        resetDut();
        base = stbLog.size();
        @(posedge clk);
        #1;
        applyStimulus(0, 8'hA1);
        applyStimulus(1, 8'hB2);
        @(posedge clk);
        #1;
        tbReqValid = '0;
        waitStrobe(base, 10, ok);
        if (ok) begin
            sCyc = stbLog[base].cyc;
            checkOutput("to_first_data", 64'(stbLog[base].data), 64'hA1);
            tCyc = -1;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (bus.o_timeout) begin
                    tCyc = cycle;
                    break;
                end
            end
            checkOutput("to_delay", 64'(tCyc - sCyc), 64'(BUSY_TO));
            waitStrobe(base + 1, 10, ok);
            if (ok) begin
                checkOutput("to_next_data", 64'(stbLog[base+1].data), 64'hB2);
                checkOutput("to_next_id", 64'(stbLog[base+1].id), 64'd1);
                checkOutput("to_next_cycle", 64'(stbLog[base+1].cyc - tCyc), 64'd1);
            end
        end
        repeat (40) @(posedge clk);
        #1;
        checkOutput("to_sticky", {63'd0, bus.o_timeout}, 64'd1);

        // Busy already high while requester 1 fills.
        resetDut();
        uartAuto   = 1'b0;
        manualBusy = 1'b1;
        base       = stbLog.size();
        @(posedge clk);
        #1;
        applyStimulus(1, 8'h3C);
        @(posedge clk);
        #1;
        tbReqValid = '0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("busy_hi_no_stb", 64'(stbLog.size() - base), 64'd0);
        manualBusy = 1'b0;
        tCyc       = cycle + 1;
        waitStrobe(base, 10, ok);
        if (ok) begin
            checkOutput("busy_hi_cycle", 64'(stbLog[base].cyc), 64'(tCyc));
            checkOutput("busy_hi_data", 64'(stbLog[base].data), 64'h3C);
            checkOutput("busy_hi_id", 64'(stbLog[base].id), 64'd1);
        end

        // Reset during WAIT_LO with requester 0 holding a second byte.
        resetDut();
        busyLen = 20;
        base    = stbLog.size();
        @(posedge clk);
        #1;
        applyStimulus(0, 8'h77);
        @(posedge clk);
        #1;
        tbReqValid = '0;
        waitStrobe(base, 10, ok);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 8'h88);
        @(posedge clk);
        #1;
        tbReqValid = '0;
        checkOutput("mid_buf_full", 64'(bus.o_req_ready), 64'(2'b10));
        arst_i = 1'b1;
        #1;
        checkOutput("mid_rst_stb", {63'd0, bus.o_tx_stb}, 64'd0);
        checkOutput("mid_rst_data", 64'(bus.o_tx_data), 64'd0);
        checkOutput("mid_rst_grant_id", 64'(bus.o_grant_id), 64'd0);
        checkOutput("mid_rst_ready", 64'(bus.o_req_ready), 64'(2'b11));
        checkCounters("mid_rst", 0, 0);
        base = stbLog.size();
        repeat (2) @(posedge clk);
        #1 arst_i = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("mid_no_stale_stb", 64'(stbLog.size() - base), 64'd0);

        // Randomized traffic against a per-requester FIFO scoreboard.
        resetDut();
        scoreOn = 1'b1;
        for (int it = 0; it < 800; it++) begin
            @(negedge clk);
            fire = tbReqValid & bus.o_req_ready;
            for (int r = 0; r < NREQ; r++) begin
                if (fire[r]) expQ[r].push_back(tbReqData[r*DW +: DW]);
            end
            @(posedge clk);
            #1;
            busyLen = $urandom_range(1, 6);
            for (int r = 0; r < NREQ; r++) begin
                if (fire[r] || !tbReqValid[r]) begin
                    tbReqValid[r]         = ($urandom_range(0, 2) != 0);
                    tbReqData[r*DW +: DW] = 8'($urandom);
                end
            end
        end
        tbReqValid = '0;
        for (int k = 0; k < 300 && (expQ[0].size() != 0 || expQ[1].size() != 0); k++) @(posedge clk);
        waitUartIdle();
        checkOutput("rand_drain_q0", 64'(expQ[0].size()), 64'd0);
        checkOutput("rand_drain_q1", 64'(expQ[1].size()), 64'd0);
        checkOutput("rand_no_timeout", {63'd0, bus.o_timeout}, 64'd0);
        checkCounters("rand", modelCnt[0], modelCnt[1]);
        scoreOn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares the single UART transmitter between NREQ byte producers, e.g. the instruction sequencer and a debug/status source on the nexys3 top.
- Each requester gets a one-entry holding buffer. A round-robin arbiter picks one full buffer, issues one strobe to the UART, then tracks i_tx_busy until the byte is finished.
- Sits between producers and uart_top; drives its i_tx_data/i_tx_stb and consumes its o_tx_busy.

Parameters:
- NREQ, 2, number of requesters (legal 2..4)
- DW, 8, data width per byte
- BUSY_TO, 16, max cycles to wait for i_tx_busy to rise after a strobe (legal 2..255)
- GW, derived, grant-id width = max(1, clog2(NREQ)); localparam, not overridable

Ports:
- clk  in  1  system clock (100 MHz)
- arst_i  in  1  reset, asynchronous, active-high
- i_req_data  in  NREQ*DW  requester r data in bits [r*DW +: DW]
- i_req_valid  in  NREQ  per-requester valid
- o_req_ready  out  NREQ  per-requester ready; high when that holding buffer is empty
- i_tx_busy  in  1  UART transmitter busy
- o_tx_data  out  DW  byte to UART; registered, held stable until next strobe
- o_tx_stb  out  1  one-cycle transmit strobe; registered
- o_grant_id  out  GW  requester index of the last strobe
- o_timeout  out  1  sticky; set when BUSY_TO expires
- o_grant_cnt  out  NREQ*16  per-requester sent-byte counters (see Optional Feature)

Behaviour:
- Reset state (arst_i high, async):
  - all buffers empty, so o_req_ready = all ones
  - o_tx_stb = 0, o_tx_data = 0, o_grant_id = 0, o_timeout = 0
  - FSM = IDLE; round-robin pointer = 0 (requester 0 has highest priority first)
- Reset mid-operation: any buffered bytes are discarded; the UART byte in flight is not tracked. After release the FSM starts in IDLE.
- Accept:
  - Transfer on i_req_valid[r] & o_req_ready[r] at a clock edge. Data is captured and buf_full[r] is set.
  - o_req_ready[r] = ~buf_full[r], taken directly from the register (no combinational path from valid).
- Round-robin pick: the first full buffer scanning from ptr, ptr+1, … modulo NREQ. After a grant to r, ptr = (r+1) mod NREQ.
- FSM states: IDLE, WAIT_HI, WAIT_LO.
  - IDLE, when any buffer is full and i_tx_busy = 0:
    - register o_tx_data = buf[g], o_tx_stb = 1, o_grant_id = g
    - clear buf_full[g], advance ptr
    - go to WAIT_HI with to_cnt = 0
  - IDLE otherwise: stay. o_tx_stb is forced to 0 every cycle it is not being set.
  - WAIT_HI:
    - if i_tx_busy = 1, go to WAIT_LO
    - else increment to_cnt; when to_cnt reaches BUSY_TO-1, set o_timeout and go to IDLE
  - WAIT_LO: when i_tx_busy = 0, go to IDLE.
- Latency: valid accepted at edge N, buf_full seen at N+1, o_tx_stb high in the cycle after edge N+1. Minimum 2 cycles from valid to strobe.
- Strobe rules: o_tx_stb is never high on two consecutive cycles, and is never issued while i_tx_busy = 1.
- Same-requester back-to-back: buffer r is cleared at the grant edge, so ready[r] rises in the same cycle o_tx_stb is high. A new byte can be accepted during the transmission.
- Simultaneous events:
  - Fill and drain of the same buffer in one edge cannot happen, because ready is low while full.
  - Fills of different requesters in the same edge are all accepted.
- Busy already high when a buffer fills: stay in IDLE until it drops.
- o_timeout is cleared only by reset.

Optional Feature:
- Macro: UART_TX_ARB_STATS_EN.
- Defined:
  - o_grant_cnt[r*16 +: 16] counts strobes granted to r; reset 0
  - counters saturate at 16'hFFFF
  - counters increment on the same edge that sets o_tx_stb
- Undefined: o_grant_cnt is tied to 0 and no counter flops are built. The port list is identical in both builds.

Decomposition:
- Package uart_tx_arb_pkg:
  - FSM state enum, 2 bits: IDLE = 0, WAIT_HI = 1, WAIT_LO = 2
  - defaults for DW and BUSY_TO
  - counter width constant STAT_W = 16
- Sub-module rr_pick:
  - purely combinational
  - inputs: full vector, ptr
  - outputs: any_full, grant index
  - reused by later arbiters

Test Plan:
- Single byte: req0 sends 8'hA5. Strobe occurs 2 cycles later with o_tx_data = A5 and o_grant_id = 0. UART model raises busy 1 cycle later for 20 cycles. ready0 is high during busy. Next strobe only after busy falls.
- Contention, NREQ = 2: both requesters hold valid in the same cycle, req0 = 8'h11, req1 = 8'h22, each refilled on ready, 4 bytes each. Strobe order is 11, 22, 11, 22, … strictly alternating, and each counter reaches 4 (stats build).
- Busy stuck low: UART model never asserts busy. o_timeout sets exactly BUSY_TO cycles after the strobe. The FSM returns to IDLE and the next queued byte strobes.
- Busy already high: i_tx_busy = 1 while req1 fills with 8'h3C. No strobe occurs; busy drops at cycle T and the strobe with 3C occurs at T+1.
- Reset mid-operation: assert arst_i during WAIT_LO with req0 buffer full. Outputs are 0 immediately (async) and ready = all ones. After release no stale byte is strobed.
- Stats build vs plain build: both builds compile from the same bench. Plain build has o_grant_cnt = 0 throughout; stats build saturates at FFFF when forced via a pre-loaded test hook or a long run.
